// File: rtl/jtkicker_snd_latch_if.sv
// Main-to-sound command channel bus.
// Main CPU writes, sound CPU reads and acknowledges.
interface jtkicker_snd_latch_if #(
  parameter int DW = 8,
  parameter int AW = 2
) ();
  logic          wr_cs;
  logic [DW-1:0] din;
  logic          irq_trig;
  logic          rd_cs;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          irq_n;
  logic          irq_ack;
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output wr_cs,
    output din,
    output irq_trig,
    output rd_cs,
    output irq_ack,
    output ovf_clr,
    input  dout,
    input  empty,
    input  full,
    input  count,
    input  irq_n,
    input  ovf
  );

  modport slave (
    input  wr_cs,
    input  din,
    input  irq_trig,
    input  rd_cs,
    input  irq_ack,
    input  ovf_clr,
    output dout,
    output empty,
    output full,
    output count,
    output irq_n,
    output ovf
  );
endinterface

// File: rtl/jtkicker_snd_latch.sv
// Main-to-sound command FIFO with sound CPU IRQ generator.
// AW=0 behaves as the legacy single overwrite latch.
module jtkicker_snd_latch #(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int AUTO_IRQ = 0,
  parameter int PULSE    = 0
) (
  input logic clk,
  input logic rst_n,
  input logic cen,
  jtkicker_snd_latch_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (PULSE > 0) ? $clog2(PULSE + 1) : 1;

  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [CW-1:0] PC_LOAD = CW'(PULSE);
  localparam logic [CW-1:0] PC_ONE  = CW'(1);

  logic          wr_l;
  logic          rd_l;
  logic          trig_l;
  logic          push;
  logic          pop;
  logic          trig;
  logic          acc;
  logic          ovf_ev;
  logic          arm;
  logic          empty;
  logic          full;
  logic [DW-1:0] dout_r;
  logic [AW:0]   cnt;
  logic          ovf_r;
  logic          irq_r;
  logic          irq_nx;
  logic [CW-1:0] pc;
  logic [CW-1:0] pc_nx;

  assign empty = (cnt == '0);
  assign full  = (AW > 0) && (cnt == FULL_C);

  assign push = bus.wr_cs & ~wr_l;
  assign pop  = bus.rd_cs & ~rd_l & ~empty;
  assign trig = bus.irq_trig & ~trig_l;
  assign arm  = trig | ((AUTO_IRQ != 0) & acc);

  assign bus.dout  = dout_r;
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.count = cnt;
  assign bus.ovf   = ovf_r;
  assign bus.irq_n = irq_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_l   <= 1'b0;
      rd_l   <= 1'b0;
      trig_l <= 1'b0;
    end else begin
      wr_l   <= bus.wr_cs;
      rd_l   <= bus.rd_cs;
      trig_l <= bus.irq_trig;
    end
  end

  generate
    if (AW == 0) begin : g_latch
      // Every push overwrites; the latch itself is dout.
      assign acc    = push;
      assign ovf_ev = 1'b0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r <= '0;
          cnt    <= '0;
        end else if (push) begin
          dout_r <= bus.din;
          cnt    <= ONE_C;
        end else if (pop) begin
          cnt    <= '0;
        end
      end
    end else begin : g_fifo
      logic [DW-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [AW-1:0] rd_nxt;

      assign rd_nxt = rd_ptr + 1'b1;
      assign acc    = push & (~full | pop);
      assign ovf_ev = push & full & ~pop;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (acc) begin
          mem[wr_ptr] <= bus.din;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
          dout_r <= '0;
        end else begin
          if (acc) wr_ptr <= wr_ptr + 1'b1;
          if (pop) rd_ptr <= rd_nxt;
          unique case ({acc, pop})
            2'b10:   cnt <= cnt + ONE_C;
            2'b01:   cnt <= cnt - ONE_C;
            default: ;
          endcase
          // Head after a pop comes from memory, or from din
          // when the only remaining entry is the one arriving now.
          if (pop) begin
            if (cnt > ONE_C) dout_r <= mem[rd_nxt];
            else if (acc)    dout_r <= bus.din;
          end else if (acc && empty) begin
            dout_r <= bus.din;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovf_r <= 1'b0;
    else if (ovf_ev)      ovf_r <= 1'b1;
    else if (bus.ovf_clr) ovf_r <= 1'b0;
  end

  always_comb begin
    irq_nx = irq_r;
    pc_nx  = pc;
    if (arm) begin
      irq_nx = 1'b0;
      pc_nx  = PC_LOAD;
    end else if (bus.irq_ack) begin
      irq_nx = 1'b1;
    end else if (PULSE > 0 && !irq_r && cen) begin
      if (pc != '0)     pc_nx  = pc - PC_ONE;
      if (pc <= PC_ONE) irq_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b1;
      pc    <= '0;
    end else begin
      irq_r <= irq_nx;
      pc    <= pc_nx;
    end
  end

endmodule

// File: tb/tb_jtkicker_snd_latch.sv
// Scoreboard bench: FIFO instance (AW=2, PULSE=4) and
// legacy latch instance (AW=0, AUTO_IRQ=1) against a queue model.
module tb_jtkicker_snd_latch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;

  always #5 clk = ~clk;

  jtkicker_snd_latch_if #(.DW(8), .AW(2)) ia ();
  jtkicker_snd_latch_if #(.DW(8), .AW(0)) ib ();

  jtkicker_snd_latch #(
    .DW(8), .AW(2), .AUTO_IRQ(0), .PULSE(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(ia)
  );

  jtkicker_snd_latch #(
    .DW(8), .AW(0), .AUTO_IRQ(1), .PULSE(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(ib)
  );

  typedef struct {
    logic [7:0] dout;
    int         count;
    bit         ovf;
  } exp_t;

  exp_t       eq_a[$];
  exp_t       eq_b[$];
  logic [7:0] mq[2][$];
  logic [7:0] mdout[2];
  bit         mov[2];

  int checks = 0;
  int failures = 0;
  bit wa = 0, ra = 0, wb = 0, rb = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mdout[d] = 8'h00;
      mov[d] = 1'b0;
    end
  endtask

  // Reference: a bounded queue; AW=0 keeps only the newest byte.
  task automatic model(input int d, input bit p, input bit r,
                       input logic [7:0] v, input bit clr);
    int   depth = (d == 0) ? 4 : 1;
    int   sz = mq[d].size();
    bit   pop_ok = r && (sz > 0);
    bit   oe = 1'b0;
    exp_t e;
    if (d == 1) begin
      if (p) begin
        mq[d].delete();
        mq[d].push_back(v);
      end else if (pop_ok) begin
        void'(mq[d].pop_front());
      end
    end else begin
      if (pop_ok) void'(mq[d].pop_front());
      if (p) begin
        if (sz < depth || pop_ok) mq[d].push_back(v);
        else oe = 1'b1;
      end
    end
    if (oe) mov[d] = 1'b1;
    else if (clr) mov[d] = 1'b0;
    if (mq[d].size() > 0) mdout[d] = mq[d][0];
    e.dout = mdout[d];
    e.count = mq[d].size();
    e.ovf = mov[d];
    if (d == 0) eq_a.push_back(e);
    else eq_b.push_back(e);
  endtask

  task automatic drive(input int d, input bit p, input bit r,
                       input logic [7:0] v, input bit clr);
    if (d == 0) begin
      ia.wr_cs = p; ia.rd_cs = r; ia.din = v; ia.ovf_clr = clr;
    end else begin
      ib.wr_cs = p; ib.rd_cs = r; ib.din = v; ib.ovf_clr = clr;
    end
  endtask

  task automatic op(input int d, input bit p, input bit r,
                    input logic [7:0] v, input bit clr = 1'b0,
                    input int hold = 1);
    @(negedge clk);
    drive(d, p, r, v, clr);
    model(d, p, r, v, clr);
    @(negedge clk);
    drive(d, p, r, v, 1'b0);
    repeat (hold - 1) @(negedge clk);
    drive(d, 1'b0, 1'b0, v, 1'b0);
  endtask

  task automatic pulse_cen();
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0;
  endtask

  task automatic trig_a();
    @(negedge clk); ia.irq_trig = 1'b1;
    @(negedge clk); ia.irq_trig = 1'b0;
  endtask

  task automatic ack(input int d);
    @(negedge clk);
    if (d == 0) ia.irq_ack = 1'b1; else ib.irq_ack = 1'b1;
    @(negedge clk);
    if (d == 0) ia.irq_ack = 1'b0; else ib.irq_ack = 1'b0;
  endtask

  always begin : mon_a
    bit   pend;
    exp_t e;
    @(posedge clk);
    pend = (ia.wr_cs && !wa) || (ia.rd_cs && !ra);
    wa = ia.wr_cs;
    ra = ia.rd_cs;
    if (pend) begin
      @(negedge clk);
      if (eq_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_sb actual=no_entry expected=entry");
      end else begin
        e = eq_a.pop_front();
        chk("a_dout", ia.dout, e.dout);
        chk("a_count", ia.count, e.count);
        chk("a_empty", ia.empty, e.count == 0);
        chk("a_full", ia.full, e.count == 4);
        chk("a_ovf", ia.ovf, e.ovf);
      end
    end
  end

  always begin : mon_b
    bit   pend;
    exp_t e;
    @(posedge clk);
    pend = (ib.wr_cs && !wb) || (ib.rd_cs && !rb);
    wb = ib.wr_cs;
    rb = ib.rd_cs;
    if (pend) begin
      @(negedge clk);
      if (eq_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_sb actual=no_entry expected=entry");
      end else begin
        e = eq_b.pop_front();
        chk("b_dout", ib.dout, e.dout);
        chk("b_count", ib.count, e.count);
        chk("b_empty", ib.empty, e.count == 0);
        chk("b_full", ib.full, 0);
        chk("b_ovf", ib.ovf, e.ovf);
      end
    end
  end

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
    ia.irq_trig = 1'b0; ia.irq_ack = 1'b0;
    ib.irq_trig = 1'b0; ib.irq_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_a_dout", ia.dout, 0);
    chk("rst_a_count", ia.count, 0);
    chk("rst_a_empty", ia.empty, 1);
    chk("rst_a_full", ia.full, 0);
    chk("rst_a_irq", ia.irq_n, 1);
    chk("rst_b_empty", ib.empty, 1);
    chk("rst_b_irq", ib.irq_n, 1);
    rst_n = 1'b1;

    // Ordering, overflow, drain, pop-when-empty with ovf_clr
    op(0, 1, 0, 8'h11, 0, 5);
    op(0, 1, 0, 8'h22, 0, 5);
    op(0, 1, 0, 8'h33, 0, 5);
    op(0, 1, 0, 8'h44, 0, 5);
    op(0, 1, 0, 8'h55, 0, 2);
    for (int i = 0; i < 4; i++) op(0, 0, 1, 8'h00, 0, 2);
    op(0, 0, 1, 8'h00, 1, 1);

    // Wrap-around
    for (int i = 0; i < 10; i++) begin
      op(0, 1, 0, 8'($urandom), 0, $urandom_range(1, 3));
      op(0, 0, 1, 8'h00, 0, 1);
    end

    // Simultaneous at full and at empty
    for (int i = 0; i < 4; i++) op(0, 1, 0, 8'(i + 1), 0, 1);
    op(0, 1, 1, 8'hA5, 0, 1);
    for (int i = 0; i < 4; i++) op(0, 0, 1, 8'h00, 0, 1);
    op(0, 1, 1, 8'h5A, 0, 1);
    op(0, 0, 1, 8'h00, 0, 1);

    // Pulse IRQ: release after four cen ticks
    trig_a();
    chk("a_arm", ia.irq_n, 0);
    for (int k = 0; k < 4; k++) begin
      pulse_cen();
      chk("a_pulse", ia.irq_n, k == 3);
    end
    // Re-arm while low restarts the counter
    trig_a();
    pulse_cen();
    pulse_cen();
    chk("a_mid", ia.irq_n, 0);
    trig_a();
    for (int k = 0; k < 4; k++) begin
      pulse_cen();
      chk("a_restart", ia.irq_n, k == 3);
    end
    trig_a();
    ack(0);
    chk("a_ack", ia.irq_n, 1);
    @(negedge clk);
    ia.irq_trig = 1'b1; ia.irq_ack = 1'b1;
    @(negedge clk);
    ia.irq_trig = 1'b0; ia.irq_ack = 1'b0;
    chk("a_arm_ack", ia.irq_n, 0);
    ack(0);
    op(0, 1, 0, 8'h77, 0, 2);
    chk("a_push_noarm", ia.irq_n, 1);
    op(0, 0, 1, 8'h00, 0, 1);

    // Legacy latch
    op(1, 1, 0, 8'h12, 0, 3);
    op(1, 1, 0, 8'h34, 0, 3);
    op(1, 0, 1, 8'h00, 0, 2);
    op(1, 0, 1, 8'h00, 0, 1);

    // Auto IRQ, level until ack
    ack(1);
    chk("b_ack0", ib.irq_n, 1);
    op(1, 1, 0, 8'h9C, 0, 1);
    chk("b_auto", ib.irq_n, 0);
    for (int k = 0; k < 5; k++) pulse_cen();
    chk("b_hold", ib.irq_n, 0);
    ack(1);
    chk("b_ack", ib.irq_n, 1);
    @(negedge clk);
    ib.irq_trig = 1'b1; ib.irq_ack = 1'b1;
    @(negedge clk);
    ib.irq_trig = 1'b0; ib.irq_ack = 1'b0;
    chk("b_arm_ack", ib.irq_n, 0);
    ack(1);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int k = $urandom_range(0, 9);
      op(0, k < 5 || k > 7, k > 4, 8'($urandom),
         $urandom_range(0, 5) == 0, $urandom_range(1, 4));
    end
    for (int i = 0; i < 60; i++) begin
      int k = $urandom_range(0, 9);
      op(1, k < 5 || k > 7, k > 4, 8'($urandom),
         $urandom_range(0, 5) == 0, $urandom_range(1, 3));
    end
    ack(0);
    while (!ia.empty && eq_a.size() == 0 && mq[0].size() > 0)
      op(0, 0, 1, 8'h00, 0, 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) op(0, 1, 0, 8'(8'hC0 + i), 0, 1);
    trig_a();
    chk("pre_rst_irq", ia.irq_n, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq", ia.irq_n, 1);
    chk("arst_count", ia.count, 0);
    chk("arst_dout", ia.dout, 0);
    chk("arst_empty", ia.empty, 1);
    chk("arst_ovf", ia.ovf, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 1, 0, 8'h3C, 0, 1);

    repeat (3) @(negedge clk);
    chk("a_drain", eq_a.size(), 0);
    chk("b_drain", eq_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtkicker_snd_latch.md
Name: jtkicker_snd_latch

Overview:
Parametrised main-to-sound command channel that replaces the single m2s data latch and sound-IRQ strobe pair used by the Kicker-family game tops. The main CPU pushes command bytes into a FIFO of configurable depth. The sound CPU pops them and is interrupted through a configurable IRQ generator. With depth 1 it reproduces the legacy overwrite latch, so existing cores can migrate without behaviour change.

Parameters:
DW, 8, data width of commands
AW, 2, FIFO address width; depth = 2**AW; AW=0 selects legacy latch mode (depth 1, overwrite)
AUTO_IRQ, 0, 0: IRQ armed only by irq_trig rising edge; 1: IRQ also armed by every accepted push
PULSE, 0, 0: irq_n held until irq_ack; N>0: irq_n auto-releases after N cen ticks (or on ack, whichever first)

Ports:
clk  in  1  system clock (24 MHz domain)
rst_n  in  1  asynchronous, active-low reset
cen  in  1  sound CPU clock enable, used only by the IRQ pulse counter
wr_cs  in  1  main CPU data-latch chip select (level, may last many clk)
din  in  DW  main CPU write data, sampled on wr_cs rising edge
irq_trig  in  1  main CPU "sound on" select (level); rising edge arms the IRQ
rd_cs  in  1  sound CPU latch read select (level)
dout  out  DW  oldest FIFO entry; holds last popped value when empty
empty  out  1  FIFO empty
full  out  1  FIFO full (never asserted when AW=0)
count  out  AW+1  occupancy, 0..2**AW
irq_n  out  1  sound CPU interrupt, active low
irq_ack  in  1  sound CPU interrupt acknowledge, one-clk pulse
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async, rst_n=0): pointers 0, count=0, empty=1, full=0, dout=0, irq_n=1, ovf=0, edge-detect registers 0, pulse counter 0.
- Edge detect: registered copies of wr_cs, rd_cs and irq_trig. Push = wr_cs & ~wr_cs_l; pop = rd_cs & ~rd_cs_l & ~empty; trig = irq_trig & ~irq_trig_l. Each event fires exactly once per select assertion.
- Push (AW>0): if not full, or full with a simultaneous pop, din is written at wr_ptr, wr_ptr wraps modulo 2**AW, and count is updated net of any pop. If full with no pop, data is dropped and ovf is set.
- Push (AW=0): the entry is always overwritten; count=1 and empty=0 after the push; ovf is never set.
- Pop: rd_ptr advances with modulo wrap and count decrements. Pop while empty is ignored with no state change.
- Push and pop in the same clk with count=0: push succeeds, pop is ignored, and the result is count=1.
- dout: registered. It updates 1 clk after any push into an empty FIFO, or after any pop with a remaining entry, to the new head. After the last pop it keeps the popped value.
- IRQ arm: trig, or an accepted push when AUTO_IRQ=1, drives irq_n=0 on the next clk. Arming while irq_n is already 0 restarts the pulse counter.
- IRQ release: irq_ack drives irq_n=1 on the next clk. If PULSE>0, the counter loads PULSE on arm, decrements on cen, and releases irq_n when it reaches 0.
- Simultaneous arm and irq_ack: arm wins, irq_n stays 0.
- ovf_clr clears ovf. A simultaneous overflow event wins.
- count is the exact occupancy; full = (count == 2**AW); empty = (count == 0).

Test Plan:
- Reset mid-operation: fill 3 entries, pull rst_n low asynchronously between clk edges -> all outputs return to reset values immediately (irq_n=1, count=0, dout=0).
- AW=2 ordering: push 0x11, 0x22, 0x33, 0x44 with wr_cs held 5 clk each, then push 0x55 -> full=1, ovf=1. Four pops return 0x11..0x44 in order; afterwards empty=1 and dout stays 0x44.
- Wrap-around: 10 alternating push/pop pairs with AW=2 -> values are returned in order, count toggles between 0 and 1, and ovf is never set.
- Simultaneous events: at full, push 0xA5 and pop in the same clk -> count stays 4, no ovf, and 0xA5 is the last entry read. At empty, push and pop in the same clk -> count=1.
- IRQ: AUTO_IRQ=0 with PULSE=4 -> irq_trig rise gives irq_n=0 next clk, released after 4 cen ticks; a push alone does not arm. AUTO_IRQ=1 with PULSE=0 -> a push arms the IRQ and irq_n stays low until irq_ack; arm coincident with ack keeps irq_n=0.
- Legacy mode AW=0: push 0x12, then push 0x34 without a pop -> dout=0x34, full=0, ovf=0. One pop -> empty=1, dout=0x34.
